// File: rtl/aes256_dec_key_sched.sv
// AES-256 decryption round-key scheduler: drives an external expansion step,
// stores all 15 round keys, then streams them last-round-first over valid/ready.
module aes256_dec_key_sched #(
    parameter int NR     = 14,
    parameter int NSTEPS = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key_in,
    output logic [3:0]   exp_rc,
    output logic [255:0] exp_key,
    input  logic [255:0] exp_keyout,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         rk_last,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_STREAM
    } state_e;

    localparam logic [3:0] LAST_RC  = 4'(NSTEPS);
    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_e         state_q, state_d;
    logic [127:0]   rk_q [0:NR];
    logic [127:0]   rk_d [0:NR];
    logic [255:0]   cur_key_q, cur_key_d;
    logic [3:0]     rc_q, rc_d;
    logic [3:0]     idx_q, idx_d;
    logic [127:0]   rk_data_q, rk_data_d;

    logic key_fire;
    assign key_fire = key_valid && (state_q == ST_IDLE);

    // NOTE: state and the round-key store use non-blocking assignments and are
    // cleared on reset so an abandoned expansion leaves no stale keys behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_key_q <= '0;
            rc_q      <= '0;
            idx_q     <= '0;
            rk_data_q <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_key_q <= cur_key_d;
            rc_q      <= rc_d;
            idx_q     <= idx_d;
            rk_data_q <= rk_data_d;
            rk_q      <= rk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (key_fire) state_d = ST_EXPAND;
            ST_EXPAND: if (rc_q == LAST_RC) state_d = ST_STREAM;
            ST_STREAM: if (rk_ready && idx_q == 4'd0) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: every variable gets its hold value first so no path infers a latch.
    always_comb begin
        rk_d      = rk_q;
        cur_key_d = cur_key_q;
        rc_d      = rc_q;
        idx_d     = idx_q;
        rk_data_d = rk_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_fire) begin
                    rk_d[0]   = key_in[255:128];
                    rk_d[1]   = key_in[127:0];
                    cur_key_d = key_in;
                    rc_d      = 4'd1;
                end
            end
            ST_EXPAND: begin
                rk_d[{rc_q[2:0], 1'b0}] = exp_keyout[255:128];
                if (rc_q != LAST_RC) begin
                    rk_d[{rc_q[2:0], 1'b1}] = exp_keyout[127:0];
                    cur_key_d               = exp_keyout;
                    rc_d                    = rc_q + 4'd1;
                end else begin
                    // Final step yields only round key 14; preload it as the first beat.
                    idx_d     = LAST_IDX;
                    rk_data_d = exp_keyout[255:128];
                end
            end
            ST_STREAM: begin
                if (rk_ready && idx_q != 4'd0) begin
                    idx_d     = idx_q - 4'd1;
                    rk_data_d = rk_q[idx_q - 4'd1];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        key_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        rk_valid  = (state_q == ST_STREAM);
        exp_rc    = (state_q == ST_EXPAND) ? rc_q : 4'd0;
        exp_key   = cur_key_q;
        rk_data   = rk_data_q;
        rk_index  = idx_q;
        rk_last   = (state_q == ST_STREAM) && (idx_q == 4'd0);
    end

endmodule

// File: tb/tb_aes256_dec_key_sched.sv
// Scoreboard bench for aes256_dec_key_sched with a behavioural AES-256
// key-expansion step attached to the exp_* port pair.
module tb_aes256_dec_key_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key_in;
    logic [3:0]   exp_rc;
    logic [255:0] exp_key;
    logic [255:0] exp_keyout;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         rk_last;
    logic         busy;

    aes256_dec_key_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .exp_rc     (exp_rc),
        .exp_key    (exp_key),
        .exp_keyout (exp_keyout),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_data    (rk_data),
        .rk_index   (rk_index),
        .rk_last    (rk_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] KEY_FIPS = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_B    = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] data;
    } beat_t;

    beat_t        exp_q[$];
    int           acc_cyc[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           since_acc = -1;
    int           n_xfer = 0;
    int           last_xfer_cyc = -100;
    bit           expect_after_xfer = 1'b0;
    bit           rand_ready = 1'b0;
    logic         ready_level = 1'b1;
    logic [127:0] cap_data [0:15];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // ---- behavioural AES-256 expansion step ----
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, b, e;
        r = 8'h01;
        b = x;
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, b);
            b = gmul(b, b);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [255:0] aes_step(input logic [255:0] k, input logic [3:0] rc);
        logic [31:0]  w [8];
        logic [31:0]  t;
        logic [7:0]   rcon;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
        rcon = (rc == 4'd0) ? 8'h00 : 8'(1 << (rc - 4'd1));
        t    = subword({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        t    = subword(w[3]);
        w[4] = w[4] ^ t;
        w[5] = w[5] ^ w[4];
        w[6] = w[6] ^ w[5];
        w[7] = w[7] ^ w[6];
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = w[i];
        return r;
    endfunction

    always_comb exp_keyout = aes_step(exp_key, exp_rc);

    task automatic push_expected(input logic [255:0] key);
        logic [127:0] rks [0:14];
        logic [255:0] k;
        beat_t        b;
        k      = key;
        rks[0] = k[255:128];
        rks[1] = k[127:0];
        for (int i = 1; i <= 7; i++) begin
            k          = aes_step(k, 4'(i));
            rks[2*i]   = k[255:128];
            if (i < 7) rks[2*i+1] = k[127:0];
        end
        for (int i = 14; i >= 0; i--) begin
            b.idx  = 4'(i);
            b.data = rks[i];
            exp_q.push_back(b);
        end
    endtask

    // ---- rk_ready driver ----
    always @(posedge clk) begin
        #1;
        rk_ready = rand_ready ? ($urandom_range(0, 9) < 3) : ready_level;
    end

    always @(posedge clk) cyc++;

    // ---- stimulus tracker: pushes expectations, checks expansion sequencing ----
    always @(negedge clk) begin
        if (!rst_n) begin
            since_acc = -1;
            exp_q.delete();
        end else begin
            if (since_acc >= 0) since_acc++;
            if (since_acc >= 1 && since_acc <= 7) begin
                check("exp_rc_seq", 256'(exp_rc), 256'(since_acc));
                check("expand_rk_valid", 256'(rk_valid), 256'(0));
                check("expand_busy", 256'(busy), 256'(1));
            end else if (since_acc == 8) begin
                check("exp_rc_after", 256'(exp_rc), 256'(0));
                check("first_valid_latency", 256'(rk_valid), 256'(1));
                since_acc = -1;
            end
            if (key_valid && key_ready) begin
                check("exp_rc_before", 256'(exp_rc), 256'(0));
                if (expect_after_xfer)
                    check("accept_after_last", 256'(cyc - last_xfer_cyc), 256'(1));
                push_expected(key_in);
                acc_cyc.push_back(cyc);
                since_acc = 0;
            end
        end
    end

    // ---- monitor: pops the scoreboard on every transfer ----
    bit           stalled = 1'b0;
    logic [127:0] held_data;
    logic [3:0]   held_idx;

    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            stalled = 1'b0;
        end else if (rk_valid) begin
            if (stalled) begin
                check("stall_data", 256'(rk_data), 256'(held_data));
                check("stall_index", 256'(rk_index), 256'(held_idx));
            end
            if (rk_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 256'(rk_index), 256'(16));
                end else begin
                    b = exp_q.pop_front();
                    check("rk_index", 256'(rk_index), 256'(b.idx));
                    check("rk_data", 256'(rk_data), 256'(b.data));
                    check("rk_last", 256'(rk_last), 256'(b.idx == 4'd0));
                end
                cap_data[rk_index] = rk_data;
                n_xfer++;
                last_xfer_cyc = cyc;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_data = rk_data;
                held_idx  = rk_index;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Holds key_valid until the DUT takes the key (accept at the next rising edge).
    task automatic send_key(input logic [255:0] k);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key_in    = k;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("key_accept_timeout", 256'(0), 256'(1));
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_ready && exp_q.size() == 0 && since_acc < 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("idle_timeout", 256'(0), 256'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_key_ready", 256'(key_ready), 256'(1));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_rk_valid", 256'(rk_valid), 256'(0));
        check("rst_rk_data", 256'(rk_data), 256'(0));
        check("rst_rk_index", 256'(rk_index), 256'(0));
        check("rst_rk_last", 256'(rk_last), 256'(0));
        check("rst_exp_rc", 256'(exp_rc), 256'(0));
        check("rst_exp_key", exp_key, 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset in the middle of expansion (rc == 4).
        send_key(KEY_FIPS);
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_exp_rc", 256'(exp_rc), 256'(4));
        rst_n = 1'b0;
        #2;
        check("mid_rst_key_ready", 256'(key_ready), 256'(1));
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_rk_valid", 256'(rk_valid), 256'(0));
        check("mid_rst_exp_rc", 256'(exp_rc), 256'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_no_output", 256'(rk_valid), 256'(0));

        // FIPS-197 C.3 key, consumer always ready.
        base = n_xfer;
        send_key(KEY_FIPS);
        wait_idle(100);
        check("fips_beats", 256'(n_xfer - base), 256'(15));
        check("fips_rk14", 256'(cap_data[14]), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));
        check("fips_rk2", 256'(cap_data[2]), 256'(128'ha573c29fa176c498a97fce93a572c09c));
        check("fips_rk1", 256'(cap_data[1]), 256'(128'h101112131415161718191a1b1c1d1e1f));
        check("fips_rk0", 256'(cap_data[0]), 256'(128'h000102030405060708090a0b0c0d0e0f));

        // Random backpressure at roughly 30% ready duty.
        base       = n_xfer;
        rand_ready = 1'b1;
        send_key(KEY_A3);
        wait_idle(600);
        rand_ready = 1'b0;
        check("bp_beats", 256'(n_xfer - base), 256'(15));

        // Second key held during STREAM is only taken after the last transfer.
        base = n_xfer;
        send_key(KEY_FIPS);
        for (int i = 0; i < 50 && !rk_valid; i++) @(negedge clk);
        check("stream_reached", 256'(rk_valid), 256'(1));
        expect_after_xfer = 1'b1;
        send_key(KEY_A3);
        expect_after_xfer = 1'b0;
        wait_idle(100);
        check("busy_rej_beats", 256'(n_xfer - base), 256'(30));

        // Back-to-back keys: 23-cycle accept period.
        base = n_xfer;
        send_key(KEY_B);
        send_key(KEY_FIPS);
        wait_idle(100);
        check("b2b_beats", 256'(n_xfer - base), 256'(30));
        check("b2b_period", 256'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 256'(23));

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
